// File: rtl/diff_io_loopback_tester.sv
// Sequencer/checker for bidirectional differential I/O pairs: loopback vector test
// with per-channel fault reporting, or tristated listen mode with synchronised rx data.
module diff_io_loopback_tester #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned ERR_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [CHANNELS-1:0] io_i,
  output logic [CHANNELS-1:0] io_o,
  output logic [CHANNELS-1:0] io_t,
  output logic [CHANNELS-1:0] rx_data,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [CHANNELS-1:0] err_mask
);

  localparam int unsigned NV = 2 * CHANNELS + 2;
  localparam int unsigned KW = $clog2(NV);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_RELEASE, S_DONE, S_LISTEN
  } state_t;

  state_t              r_state;
  logic [KW-1:0]       r_k;
  logic [SW-1:0]       r_cnt;
  logic [CHANNELS-1:0] r_sync1, r_sync2;
  logic [CHANNELS-1:0] r_io_o, r_io_t, r_rx_data, r_err_mask;
  logic [ERR_W-1:0]    r_err_cnt;
  logic                r_busy, r_done, r_pass;

  logic [KW-1:0]       w_k_next;
  logic [CHANNELS-1:0] w_vec0, w_vec_next, w_diff;

  // Walking one, walking zero, all zero, all one.
  function automatic logic [CHANNELS-1:0] vec_of(input logic [KW-1:0] k);
    logic [CHANNELS-1:0] v;
    int unsigned         ki;
    v  = '0;
    ki = 32'(k);
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (ki < CHANNELS)            v[c] = (ki == c);
      else if (ki < 2 * CHANNELS)   v[c] = ((ki - CHANNELS) != c);
      else if (ki == 2 * CHANNELS)  v[c] = 1'b0;
      else                          v[c] = 1'b1;
    end
    return v;
  endfunction

  assign w_k_next   = r_k + 1'b1;
  assign w_vec0     = vec_of('0);
  assign w_vec_next = vec_of(w_k_next);
  assign w_diff     = r_sync2 ^ r_io_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= io_i;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_cnt      <= '0;
      r_io_o     <= '0;
      r_io_t     <= '1;
      r_rx_data  <= '0;
      r_err_cnt  <= '0;
      r_err_mask <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            if (mode) begin
              r_state <= S_LISTEN;
            end else begin
              r_state    <= S_DRIVE;
              r_k        <= '0;
              r_err_cnt  <= '0;
              r_err_mask <= '0;
              r_io_o     <= w_vec0;
              r_io_t     <= '0;
            end
          end
        end
        S_DRIVE: begin
          r_cnt   <= '0;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == SW'(SETTLE_CYCLES - 1)) r_state <= S_SAMPLE;
          else                                 r_cnt   <= r_cnt + 1'b1;
        end
        S_SAMPLE: begin
          r_err_mask <= r_err_mask | w_diff;
          if ((w_diff != '0) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
          if (r_k == KW'(NV - 1)) begin
            r_state <= S_RELEASE;
            r_io_t  <= '1;
            r_io_o  <= '0;
          end else begin
            r_k     <= w_k_next;
            r_io_o  <= w_vec_next;
            r_state <= S_DRIVE;
          end
        end
        S_RELEASE: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (r_err_cnt == '0);
        end
        S_LISTEN: begin
          r_rx_data <= r_sync2;
          if (!mode) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_o     = r_io_o;
  assign io_t     = r_io_t;
  assign rx_data  = r_rx_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_cnt  = r_err_cnt;
  assign err_mask = r_err_mask;

endmodule

// File: tb/tb_diff_io_loopback_tester.sv
// Directed bench for diff_io_loopback_tester: CH=2, SETTLE=2, plus an ERR_W=2
// instance whose pads always read back inverted.
module tb_diff_io_loopback_tester;

  logic       clk = 1'b0;
  logic       rst_n, start, mode;
  logic [1:0] io_i, io_o, io_t, rx_data, err_mask;
  logic       busy, done, pass;
  logic [7:0] err_cnt;

  logic [1:0] io_i2, io_o2, io_t2, rx_data2, err_mask2;
  logic       busy2, done2, pass2;
  logic [1:0] err_cnt2;

  int         errors = 0;
  int         checks = 0;
  int         sel;
  logic [1:0] ext;
  logic [1:0] exp_vec [6];

  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      0:       io_i = io_o;
      1:       io_i = {1'b0, io_o[0]};
      default: io_i = ext;
    endcase
  end

  assign io_i2 = ~io_o2;

  diff_io_loopback_tester #(.CHANNELS(2), .SETTLE_CYCLES(2), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .io_i(io_i),
    .io_o(io_o), .io_t(io_t), .rx_data(rx_data), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .err_mask(err_mask)
  );

  diff_io_loopback_tester #(.CHANNELS(2), .SETTLE_CYCLES(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .io_i(io_i2),
    .io_o(io_o2), .io_t(io_t2), .rx_data(rx_data2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err_cnt2), .err_mask(err_mask2)
  );

  // cycles counts clock edges from the one that samples start (inclusive) to done=1.
  task automatic run_loopback(input bit disturb, output int cycles, output int seq_err);
    cycles  = 0;
    seq_err = 0;
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (disturb && n == 10) begin start = 1'b1; mode = 1'b1; end
      if (disturb && n == 11) begin start = 1'b0; mode = 1'b0; end
      if (n <= 24) begin
        if (io_t !== 2'b00 || io_o !== exp_vec[(n-1)/4] || busy !== 1'b1) seq_err++;
      end else if (n == 25) begin
        if (io_t !== 2'b11 || io_o !== 2'b00 || busy !== 1'b1) seq_err++;
      end
      if (done === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    sel   = 0;
    ext   = 2'b00;
    repeat (2) @(negedge clk);
    checks++; if (io_t !== 2'b11)   begin errors++; $display("FAIL reset_io_t got=%b exp=11", io_t); end
    checks++; if (io_o !== 2'b00)   begin errors++; $display("FAIL reset_io_o got=%b exp=00", io_o); end
    checks++; if (rx_data !== 2'b00) begin errors++; $display("FAIL reset_rx got=%b exp=00", rx_data); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (err_mask !== 2'b00) begin errors++; $display("FAIL reset_err_mask got=%b exp=00", err_mask); end
    checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {busy, done, pass}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loopback_clean;
    int cyc, serr;
    sel = 0;
    run_loopback(1'b0, cyc, serr);
    checks++; if (cyc !== 26)  begin errors++; $display("FAIL clean_len got=%0d exp=26", cyc); end
    checks++; if (serr !== 0)  begin errors++; $display("FAIL clean_seq got=%0d bad cycles exp=0", serr); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL clean_pass got=%b exp=1", pass); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL clean_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (err_mask !== 2'b00) begin errors++; $display("FAIL clean_err_mask got=%b exp=00", err_mask); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clean_busy got=%b exp=0", busy); end
  endtask

  task automatic test_stuck_bit;
    int cyc, serr;
    sel = 1;
    run_loopback(1'b0, cyc, serr);
    checks++; if (cyc !== 26)  begin errors++; $display("FAIL stuck_len got=%0d exp=26", cyc); end
    checks++; if (err_mask !== 2'b10) begin errors++; $display("FAIL stuck_err_mask got=%b exp=10", err_mask); end
    checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL stuck_err_cnt got=%0d exp=3", err_cnt); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL stuck_pass got=%b exp=0", pass); end
    // Results must hold in DONE.
    repeat (5) @(negedge clk);
    checks++; if ({done, err_cnt} !== {1'b1, 8'd3}) begin errors++; $display("FAIL stuck_hold got=%b/%0d exp=1/3", done, err_cnt); end
    sel = 0;
  endtask

  task automatic test_back_to_back;
    int cyc, serr;
    sel = 0;
    run_loopback(1'b0, cyc, serr);
    checks++; if (cyc !== 26)  begin errors++; $display("FAIL b2b_len got=%0d exp=26", cyc); end
    checks++; if (serr !== 0)  begin errors++; $display("FAIL b2b_seq got=%0d bad cycles exp=0", serr); end
    checks++; if ({pass, err_cnt, err_mask} !== {1'b1, 8'd0, 2'b00}) begin
      errors++; $display("FAIL b2b_cleared got=%b/%0d/%b exp=1/0/00", pass, err_cnt, err_mask);
    end
  endtask

  task automatic test_saturate;
    int cyc, serr;
    sel = 0;
    run_loopback(1'b0, cyc, serr);
    checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL sat_done got=%b exp=1", done2); end
    checks++; if (err_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_err_cnt got=%0d exp=3", err_cnt2); end
    checks++; if (err_mask2 !== 2'b11) begin errors++; $display("FAIL sat_err_mask got=%b exp=11", err_mask2); end
    checks++; if (pass2 !== 1'b0) begin errors++; $display("FAIL sat_pass got=%b exp=0", pass2); end
  endtask

  task automatic test_listen;
    sel = 2;
    ext = 2'b10;
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rx_data !== 2'b10) begin errors++; $display("FAIL listen_rx got=%b exp=10", rx_data); end
    checks++; if (io_t !== 2'b11) begin errors++; $display("FAIL listen_io_t got=%b exp=11", io_t); end
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL listen_flags got=%b exp=10", {busy, done}); end
    mode = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL listen_exit_busy got=%b exp=0", busy); end
    ext = 2'b01;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 2'b10) begin errors++; $display("FAIL listen_hold got=%b exp=10", rx_data); end
    sel = 0;
  endtask

  task automatic test_reset_mid;
    int cyc, serr;
    sel = 0;
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    checks++; if ({io_t, io_o} !== {2'b00, exp_vec[3]}) begin
      errors++; $display("FAIL mid_pre_drive got=%b/%b exp=00/%b", io_t, io_o, exp_vec[3]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({io_t, io_o, busy} !== 5'b11000) begin
      errors++; $display("FAIL mid_async_reset got=%b/%b/%b exp=11/00/0", io_t, io_o, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_loopback(1'b0, cyc, serr);
    checks++; if (cyc !== 26) begin errors++; $display("FAIL mid_restart_len got=%0d exp=26", cyc); end
    checks++; if (serr !== 0) begin errors++; $display("FAIL mid_restart_seq got=%0d bad cycles exp=0", serr); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL mid_restart_pass got=%b exp=1", pass); end
  endtask

  task automatic test_ignore_start;
    int cyc, serr;
    sel = 0;
    run_loopback(1'b1, cyc, serr);
    checks++; if (cyc !== 26) begin errors++; $display("FAIL ignore_len got=%0d exp=26", cyc); end
    checks++; if (serr !== 0) begin errors++; $display("FAIL ignore_seq got=%0d bad cycles exp=0", serr); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ignore_pass got=%b exp=1", pass); end
  endtask

  initial begin
    exp_vec[0] = 2'b01;
    exp_vec[1] = 2'b10;
    exp_vec[2] = 2'b10;
    exp_vec[3] = 2'b01;
    exp_vec[4] = 2'b00;
    exp_vec[5] = 2'b11;
    test_reset();
    test_loopback_clean();
    test_stuck_bit();
    test_back_to_back();
    test_saturate();
    test_listen();
    test_reset_mid();
    test_ignore_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
